fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_SIZE, default 32'h0800: instruction memory size in bytes, a power of two; PC wraps modulo IMEM_SIZE.
REQ-003 SHALL have parameter HALT_WORD, default 32'h0000_000D (BREAK): instruction word that halts fetch.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  downstream hold request; freezes PC and IF/ID register.
REQ-007 redirect  input  1  branch/jump taken; loads new PC and flushes IF/ID.
REQ-008 redirect_target  input  32  byte address of the next instruction when redirect=1.
REQ-009 imem_address  output  32  byte address driven to the asynchronous-read instruction memory.
REQ-010 imem_instruction  input  32  word returned by the instruction memory for imem_address in the same cycle.
REQ-011 if_pc  output  32  PC of the instruction held in IF/ID.
REQ-012 if_pc_plus4  output  32  if_pc+4, wrapped modulo IMEM_SIZE.
REQ-013 if_instruction  output  32  instruction held in IF/ID.
REQ-014 if_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
REQ-015 halted  output  1  fetch is in HALT state.

Function
REQ-016 imem_address SHALL equal the PC register combinationally, with zero added latency.
REQ-017 The PC SHALL always be word-aligned (bits [1:0]=0) and below IMEM_SIZE.
REQ-018 The block SHALL implement a two-state machine, RUN and HALT.
REQ-019 In RUN, with stall=0 and redirect=0, each edge SHALL: capture PC, PC+4, and imem_instruction into IF/ID; set if_valid=1; advance PC to (PC+4) mod IMEM_SIZE.
REQ-020 Wrap: PC=IMEM_SIZE-4 SHALL advance to 0, and if_pc_plus4 SHALL then read 0.
REQ-021 With stall=1 and redirect=0, PC, IF/ID, and state SHALL hold unchanged.
REQ-022 With redirect=1, regardless of stall or state, the edge SHALL: load PC with redirect_target & (IMEM_SIZE-1) & ~3; set if_valid=0 and if_instruction=0 (NOP); clear if_pc and if_pc_plus4 to 0; enter RUN.
REQ-023 Priority SHALL be reset > redirect > stall > normal fetch.
REQ-024 In RUN, when a captured imem_instruction equals HALT_WORD, it SHALL be captured with if_valid=1 and the state SHALL become HALT on that same edge.
REQ-025 PC SHALL NOT advance on the edge that captures HALT_WORD, nor on any edge while in HALT.
REQ-026 In HALT, with stall=0 and redirect=0, each edge SHALL set if_valid=0 and leave PC unchanged.
REQ-027 In HALT, stall=1 SHALL hold IF/ID, so the HALT_WORD remains valid downstream.
REQ-028 halted SHALL be 1 exactly when the state is HALT.
REQ-029 HALT SHALL be left only by redirect or reset.

Reset
REQ-030 Reset SHALL apply on the clock edge where reset=1, overriding all other inputs.
REQ-031 Reset values SHALL be: PC=RESET_PC & (IMEM_SIZE-1) & ~3, if_pc=0, if_pc_plus4=0, if_instruction=0, if_valid=0, halted=0, state RUN.
REQ-032 Reset asserted mid-stall or mid-HALT SHALL produce the same values as REQ-031.
REQ-033 The first instruction SHALL be captured on the first edge after reset deasserts.

Configuration
REQ-034 Macro FETCH_COUNT_EN SHALL, when defined, add output fetch_count (output, 32 bits): the number of edges that set if_valid=1 via REQ-019 or REQ-024.
REQ-035 With FETCH_COUNT_EN defined, reset SHALL clear fetch_count to 0, and fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-036 With FETCH_COUNT_EN undefined, there SHALL be no fetch_count port or counter logic, and all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then 3 edges with memory words A,B,C at 0,4,8 -> if_pc 0,4,8; if_instruction A,B,C; if_valid=1; imem_address 12.
REQ-038 stall=1 for 2 edges at PC=8 -> imem_address stays 8 and IF/ID unchanged; after release, if_pc=8.
REQ-039 redirect=1 with target 32'h0000_1236 and stall=1 on the same edge -> PC=32'h0000_0234 (IMEM_SIZE=0x800), if_valid=0, if_instruction=0.
REQ-040 PC=0x7FC, no stall -> next PC=0, if_pc=0x7FC, if_pc_plus4=0.
REQ-041 Word 32'h0000_000D at PC 0x10 -> if_valid=1 for one edge, then 0; halted=1; PC stays 0x10; redirect to 0 -> halted=0, fetch resumes at 0.
REQ-042 With FETCH_COUNT_EN: 5 fetches, 2 stalls, 1 redirect -> fetch_count=5; assert reset -> fetch_count=0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch stage bus: redirect/stall control, instruction memory port and IF/ID outputs.
// fetch_count exists only when FETCH_COUNT_EN is defined.
interface fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    // master is the fetch stage; slave is the pipeline/memory side around it
    modport master (
        input  stall, redirect, redirect_target, imem_instruction,
        output imem_address, if_pc, if_pc_plus4, if_instruction, if_valid, halted
`ifdef FETCH_COUNT_EN
        , output fetch_count
`endif
    );

    modport slave (
        output stall, redirect, redirect_target, imem_instruction,
        input  imem_address, if_pc, if_pc_plus4, if_instruction, if_valid, halted
`ifdef FETCH_COUNT_EN
        , input fetch_count
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with RUN/HALT control, redirect flush and stall hold.
// Optional saturating fetch counter enabled by defining FETCH_COUNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] IMEM_SIZE = 32'h0000_0800,
    parameter logic [31:0] HALT_WORD = 32'h0000_000D
) (
    input  logic     clock,
    input  logic     reset,
    fetch_if.master  bus
);
    localparam logic [31:0] PC_MASK    = (IMEM_SIZE - 32'd1) & ~32'd3;
    localparam logic [31:0] PC_AT_RESET = RESET_PC & PC_MASK;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus4;
    logic [31:0] r_if_instruction;
    logic        r_if_valid;
    logic [31:0] w_pc_plus4;
    logic        w_is_halt;

    assign w_pc_plus4 = (r_pc + 32'd4) & PC_MASK;
    assign w_is_halt  = (bus.imem_instruction == HALT_WORD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= ST_RUN;
            r_pc             <= PC_AT_RESET;
            r_if_pc          <= 32'd0;
            r_if_pc_plus4    <= 32'd0;
            r_if_instruction <= 32'd0;
            r_if_valid       <= 1'b0;
        end else if (bus.redirect) begin
            r_state          <= ST_RUN;
            r_pc             <= bus.redirect_target & PC_MASK;
            r_if_pc          <= 32'd0;
            r_if_pc_plus4    <= 32'd0;
            r_if_instruction <= 32'd0;
            r_if_valid       <= 1'b0;
        end else if (!bus.stall) begin
            case (r_state)
                ST_RUN: begin
                    r_if_pc          <= r_pc;
                    r_if_pc_plus4    <= w_pc_plus4;
                    r_if_instruction <= bus.imem_instruction;
                    r_if_valid       <= 1'b1;
                    // the halting word is delivered but PC stays on it
                    if (w_is_halt) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_pc <= w_pc_plus4;
                    end
                end
                ST_HALT: begin
                    r_if_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
        end else if (!bus.redirect && !bus.stall && r_state == ST_RUN
                     && r_fetch_count != 32'hFFFF_FFFF) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.fetch_count = r_fetch_count;
`endif

    assign bus.imem_address   = r_pc;
    assign bus.if_pc          = r_if_pc;
    assign bus.if_pc_plus4    = r_if_pc_plus4;
    assign bus.if_instruction = r_if_instruction;
    assign bus.if_valid       = r_if_valid;
    assign bus.halted         = (r_state == ST_HALT);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a behavioural async-read memory.
// Define FETCH_COUNT_EN for both RTL and bench to exercise the fetch counter.
module tb_fetch_stage;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] mem [0:511];

    fetch_if bus ();

    fetch_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_instruction = mem[bus.imem_address[10:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle away from it for sampling/driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'd0;
        step();
        step();
        checks++;
        if (bus.imem_address !== 32'h0) begin
            errors++; $display("FAIL reset_pc got %h want %h", bus.imem_address, 32'h0);
        end
        checks++;
        if ({bus.if_pc, bus.if_pc_plus4, bus.if_instruction} !== 96'd0) begin
            errors++; $display("FAIL reset_ifid got %h %h %h want 0 0 0",
                               bus.if_pc, bus.if_pc_plus4, bus.if_instruction);
        end
        checks++;
        if ({bus.if_valid, bus.halted} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got %b%b want 00", bus.if_valid, bus.halted);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_word [0:2];
        exp_word[0] = 32'h1111_AAAA;
        exp_word[1] = 32'h2222_BBBB;
        exp_word[2] = 32'h3333_CCCC;
        for (int i = 0; i < 3; i++) mem[i] = exp_word[i];
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.if_pc !== 32'(i * 4) || bus.if_instruction !== exp_word[i] || bus.if_valid !== 1'b1) begin
                errors++; $display("FAIL seq_%0d got pc=%h ins=%h v=%b want pc=%h ins=%h v=1",
                                   i, bus.if_pc, bus.if_instruction, bus.if_valid, 32'(i * 4), exp_word[i]);
            end
        end
        checks++;
        if (bus.imem_address !== 32'd12) begin
            errors++; $display("FAIL seq_addr got %h want %h", bus.imem_address, 32'd12);
        end
    endtask

    task automatic test_stall();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.imem_address !== 32'd8 || bus.if_pc !== 32'd4 || bus.if_instruction !== 32'h2222_BBBB
                || bus.if_valid !== 1'b1) begin
                errors++; $display("FAIL stall_%0d got addr=%h pc=%h ins=%h v=%b want addr=8 pc=4 ins=2222bbbb v=1",
                                   i, bus.imem_address, bus.if_pc, bus.if_instruction, bus.if_valid);
            end
        end
        bus.stall = 1'b0;
        step();
        checks++;
        if (bus.if_pc !== 32'd8 || bus.if_instruction !== 32'h3333_CCCC || bus.imem_address !== 32'd12) begin
            errors++; $display("FAIL stall_release got pc=%h ins=%h addr=%h want pc=8 ins=3333cccc addr=c",
                               bus.if_pc, bus.if_instruction, bus.imem_address);
        end
    endtask

    task automatic test_redirect();
        mem[32'h234 >> 2] = 32'h4444_DDDD;
        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h0000_1236;
        step();
        checks++;
        if (bus.imem_address !== 32'h0000_0234) begin
            errors++; $display("FAIL redir_pc got %h want %h", bus.imem_address, 32'h234);
        end
        checks++;
        if (bus.if_valid !== 1'b0 || bus.if_instruction !== 32'd0 || bus.if_pc !== 32'd0 || bus.if_pc_plus4 !== 32'd0) begin
            errors++; $display("FAIL redir_flush got v=%b ins=%h pc=%h p4=%h want 0 0 0 0",
                               bus.if_valid, bus.if_instruction, bus.if_pc, bus.if_pc_plus4);
        end
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        step();
        checks++;
        if (bus.if_pc !== 32'h234 || bus.if_pc_plus4 !== 32'h238 || bus.if_instruction !== 32'h4444_DDDD) begin
            errors++; $display("FAIL redir_fetch got pc=%h p4=%h ins=%h want 234 238 4444dddd",
                               bus.if_pc, bus.if_pc_plus4, bus.if_instruction);
        end
    endtask

    task automatic test_wrap();
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h0000_07FC;
        step();
        bus.redirect = 1'b0;
        step();
        checks++;
        if (bus.imem_address !== 32'd0 || bus.if_pc !== 32'h7FC || bus.if_pc_plus4 !== 32'd0) begin
            errors++; $display("FAIL wrap got addr=%h pc=%h p4=%h want 0 7fc 0",
                               bus.imem_address, bus.if_pc, bus.if_pc_plus4);
        end
    endtask

    task automatic test_halt();
        mem[4] = 32'h0000_000D;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h10;
        step();
        bus.redirect = 1'b0;
        step();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_instruction !== 32'hD || bus.halted !== 1'b1
            || bus.imem_address !== 32'h10) begin
            errors++; $display("FAIL halt_enter got v=%b ins=%h h=%b addr=%h want 1 d 1 10",
                               bus.if_valid, bus.if_instruction, bus.halted, bus.imem_address);
        end
        bus.stall = 1'b1;
        step();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.halted !== 1'b1) begin
            errors++; $display("FAIL halt_stall got v=%b h=%b want 1 1", bus.if_valid, bus.halted);
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.if_valid !== 1'b0 || bus.halted !== 1'b1 || bus.imem_address !== 32'h10) begin
                errors++; $display("FAIL halt_idle_%0d got v=%b h=%b addr=%h want 0 1 10",
                                   i, bus.if_valid, bus.halted, bus.imem_address);
            end
        end
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h0;
        step();
        bus.redirect = 1'b0;
        checks++;
        if (bus.halted !== 1'b0 || bus.imem_address !== 32'h0) begin
            errors++; $display("FAIL halt_exit got h=%b addr=%h want 0 0", bus.halted, bus.imem_address);
        end
        step();
        checks++;
        if (bus.if_pc !== 32'h0 || bus.if_valid !== 1'b1 || bus.if_instruction !== 32'h1111_AAAA) begin
            errors++; $display("FAIL halt_resume got pc=%h v=%b ins=%h want 0 1 1111aaaa",
                               bus.if_pc, bus.if_valid, bus.if_instruction);
        end
    endtask

    task automatic test_reset_in_halt();
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h10;
        step();
        bus.redirect = 1'b0;
        step();
        bus.stall = 1'b1;
        reset = 1'b1;
        step();
        checks++;
        if (bus.halted !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_address !== 32'h0
            || bus.if_instruction !== 32'h0 || bus.if_pc !== 32'h0) begin
            errors++; $display("FAIL reset_halt got h=%b v=%b addr=%h ins=%h pc=%h want 0 0 0 0 0",
                               bus.halted, bus.if_valid, bus.imem_address, bus.if_instruction, bus.if_pc);
        end
        reset = 1'b0;
        bus.stall = 1'b0;
        step();
        checks++;
        if (bus.if_pc !== 32'h0 || bus.if_valid !== 1'b1 || bus.imem_address !== 32'h4) begin
            errors++; $display("FAIL reset_first got pc=%h v=%b addr=%h want 0 1 4",
                               bus.if_pc, bus.if_valid, bus.imem_address);
        end
    endtask

`ifdef FETCH_COUNT_EN
    task automatic test_fetch_count();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.stall = 1'b1;
        step();
        step();
        bus.stall = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h40;
        step();
        bus.redirect = 1'b0;
        step();
        step();
        checks++;
        if (bus.fetch_count !== 32'd5) begin
            errors++; $display("FAIL count_val got %0d want 5", bus.fetch_count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.fetch_count !== 32'd0) begin
            errors++; $display("FAIL count_reset got %0d want 0", bus.fetch_count);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | 32'(i);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_in_halt();
`ifdef FETCH_COUNT_EN
        test_fetch_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
